// File: rtl/dmem_dump_reader.sv
// Streams a contiguous word range out of the data BRAM debug read port onto a valid/ready
// interface. The core stays stalled for the whole dump so the memory contents cannot change.
module dmem_dump_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last
);

    localparam int SUM_W = ADDR_WIDTH + CNT_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_STALL = 3'd2,
        S_ADDR  = 3'd3,
        S_CAPT  = 3'd4,
        S_SEND  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cpu_stall_q, cpu_stall_d;
    logic [ADDR_WIDTH-1:0] dbg_addr_q, dbg_addr_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic                  m_last_q, m_last_d;

    logic [SUM_W-1:0]      end_addr_s;
    logic                  req_bad_s;

    // End address is computed wide enough that a huge count can never wrap into range.
    assign end_addr_s = SUM_W'(cur_addr_q) + (SUM_W'(remaining_q) << 2);
    assign req_bad_s  = (cur_addr_q[1:0] != 2'b00) || (end_addr_s > (SUM_W'(1) << ADDR_WIDTH));

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        dbg_addr_d  = dbg_addr_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_addr_d    = m_addr_q;
        m_last_d    = m_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    state_d     = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (req_bad_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (remaining_q == {CNT_WIDTH{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: state_d = S_ADDR;
            S_ADDR: begin
                dbg_addr_d = cur_addr_q;
                state_d    = S_CAPT;
            end
            S_CAPT: begin
                m_data_d  = dbg_data;
                m_addr_d  = cur_addr_q;
                m_last_d  = (remaining_q == CNT_WIDTH'(1));
                m_valid_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    m_last_d    = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(4);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    state_d     = (remaining_q == CNT_WIDTH'(1)) ? S_DONE : S_ADDR;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        cpu_stall_d = (state_d != S_IDLE) && (state_d != S_CHECK);
    end

    // State and registered outputs; reset clears everything, so no done pulse follows an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= {ADDR_WIDTH{1'b0}};
            remaining_q <= {CNT_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_stall_q <= 1'b0;
            dbg_addr_q  <= {ADDR_WIDTH{1'b0}};
            m_valid_q   <= 1'b0;
            m_data_q    <= {DATA_WIDTH{1'b0}};
            m_addr_q    <= {ADDR_WIDTH{1'b0}};
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_stall_q <= cpu_stall_d;
            dbg_addr_q  <= dbg_addr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_addr_q    <= m_addr_d;
            m_last_q    <= m_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_stall = cpu_stall_q;
    assign dbg_addr  = dbg_addr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_addr    = m_addr_q;
    assign m_last    = m_last_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader: a BRAM model answers the debug port, expected beats
// are queued when a dump is requested and popped as the DUT hands them over.
module tb_dmem_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [8:0]  word_count;
    logic        busy, done, err, cpu_stall;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic [9:0]  m_addr;

    logic [31:0] mem [256];

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;
    beat_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dbg_data = mem[dbg_addr[9:2]];

    dmem_dump_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .err(err), .cpu_stall(cpu_stall),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one dump request and follow it to completion. Cycle 1 is the cycle start is
    // presented; hold = cycles m_ready stays low on each beat; restart_at re-pulses start.
    task automatic run_dump(input logic [9:0] base, input int cnt, input int hold,
                            input logic exp_err, input int restart_at);
        beat_t       b;
        int          cyc, wt, beats, done_n, done_c, err_c, first_v;
        logic        stall_seen, both, finished;
        logic [31:0] pd;
        logic [9:0]  pa;
        wt = 0; beats = 0; done_n = 0; done_c = -1; err_c = -1; first_v = -1;
        stall_seen = 1'b0; both = 1'b0; finished = 1'b0; pd = 32'h0; pa = 10'h0;
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++) begin
                b.a = base + 10'(4 * i);
                b.d = mem[(int'(base) >> 2) + i];
                b.l = (i == cnt - 1);
                exp_q.push_back(b);
            end
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; word_count = 9'(cnt); m_ready = 1'b0;
        @(negedge clk);
        cyc = 2;
        for (int k = 0; k < 2000; k++) begin
            start = (cyc == restart_at);
            if (cpu_stall) stall_seen = 1'b1;
            if (done && err) both = 1'b1;
            if (err) err_c = cyc;
            if (done) begin done_n++; done_c = cyc; end
            m_ready = 1'b0;
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                if (wt > 0) begin
                    check("hold_data", 64'(m_data), 64'(pd));
                    check("hold_addr", 64'(m_addr), 64'(pa));
                end
                pd = m_data; pa = m_addr;
                if (wt >= hold) begin
                    m_ready = 1'b1;
                    wt = 0;
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 64'(1), 64'(0));
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_addr", 64'(m_addr), 64'(b.a));
                        check("beat_data", 64'(m_data), 64'(b.d));
                        check("beat_last", 64'(m_last), 64'(b.l));
                    end
                end else begin
                    wt++;
                end
            end
            if (done || err) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b0;
        check("finished", 64'(finished), 64'(1));
        check("done_err_same_cycle", 64'(both), 64'(0));
        if (exp_err) begin
            check("err_cycle", 64'(err_c), 64'(3));
            check("err_no_stall", 64'(stall_seen), 64'(0));
            check("err_no_beats", 64'(beats), 64'(0));
            check("err_no_done", 64'(done_n), 64'(0));
        end else begin
            check("done_count", 64'(done_n), 64'(1));
            check("no_err", 64'(err_c), 64'(-1));
            check("stall_seen", 64'(stall_seen), 64'(1));
            check("beat_count", 64'(beats), 64'(cnt));
            check("queue_empty", 64'(exp_q.size()), 64'(0));
            if (cnt > 0) begin
                check("first_valid_cycle", 64'(first_v), 64'(6));
                check("done_cycle", 64'(done_c), 64'(4 + 3 * cnt + cnt * hold));
            end else begin
                check("done_cycle_cnt0", 64'(done_c), 64'(3));
                check("cnt0_no_valid", 64'(first_v), 64'(-1));
            end
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after", 64'({busy, cpu_stall, done, err, m_valid}), 64'(0));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'd4; mem[1] = 32'd3; mem[2] = 32'd8;
        mem[255] = 32'hDEADBEEF;
        start = 1'b0; base_addr = 10'h0; word_count = 9'h0; m_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset_state",
                 64'({busy, done, err, cpu_stall, m_valid, m_last, dbg_addr, m_data, m_addr}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // T1 basic dump, T2 back-pressure on every beat
        run_dump(10'h000, 3, 0, 1'b0, -1);
        run_dump(10'h000, 3, 4, 1'b0, -1);
        // T3 empty dump
        run_dump(10'h010, 0, 0, 1'b0, -1);
        // T4 rejects and top-of-memory boundary
        run_dump(10'h002, 1, 0, 1'b1, -1);
        run_dump(10'h3FC, 2, 0, 1'b1, -1);
        run_dump(10'h000, 257, 0, 1'b1, -1);
        run_dump(10'h3FC, 1, 0, 1'b0, -1);
        run_dump(10'h000, 256, 0, 1'b0, -1);
        // T6 start re-pulsed while busy
        run_dump(10'h020, 4, 1, 1'b0, 5);
        run_dump(10'h010, 0, 0, 1'b0, 3);

        // T5 reset during the second SEND of a 3-word dump
        @(negedge clk);
        start = 1'b1; base_addr = 10'h000; word_count = 9'd3; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && !m_valid; k++) @(negedge clk);
        check("t5_beat1_data", 64'({m_valid, m_data}), 64'({1'b1, 32'd4}));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        for (int k = 0; k < 50 && !m_valid; k++) @(negedge clk);
        check("t5_beat2_addr", 64'({m_valid, cpu_stall, m_addr}), 64'({1'b1, 1'b1, 10'h004}));
        #2 rst = 1'b0;
        #1 check("t5_async_reset",
                 64'({busy, done, err, cpu_stall, m_valid, m_last, dbg_addr, m_data, m_addr}), 64'(0));
        @(negedge clk);
        check("t5_held_in_reset", 64'({busy, done, cpu_stall, m_valid}), 64'(0));
        rst = 1'b1;
        run_dump(10'h000, 3, 0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
